// File: rtl/vga_timing.sv
// vga_timing: 640x480 raster timing generator and pixel output stage.
// Produces the x/y/en coordinate stream for the sprite blocks. Samples their
// rgb result one pixel period later, blanks it outside the visible area and
// presents colour and sync pins aligned PIPE_DLY pixel periods behind x/y.

module vga_timing #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int CLK_DIV   = 4,    // clk cycles per pixel, 2..16
    parameter int PIPE_DLY  = 2     // pixel periods from coordinate to colour/sync, 1..4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] rgb,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       en,
    output logic       frame_start,
    output logic       hsync,
    output logic       vsync,
    output logic [2:0] red,
    output logic [2:0] green,
    output logic [1:0] blue
);

    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_END    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS_END    = 10'(V_VISIBLE);
    localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
    localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FP + V_SYNC);
    localparam logic [3:0] DIV_LAST     = 4'(CLK_DIV - 1);

    // The sprite returns colour one pixel period after the coordinate, so the
    // colour register sits at the stage after the first sync stage. With
    // PIPE_DLY=1 the sprite is assumed to answer within the same period.
    localparam int COL_DLY = (PIPE_DLY > 1) ? PIPE_DLY - 1 : 1;

    logic [3:0]          div_q,   div_d;
    logic                en_q,    en_d;
    logic                fs_q,    fs_d;
    logic [9:0]          x_q,     x_d;
    logic [9:0]          y_q,     y_d;
    logic [PIPE_DLY-1:0] hPipe_q, hPipe_d;
    logic [PIPE_DLY-1:0] vPipe_q, vPipe_d;
    logic                visD1_q, visD1_d;
    logic [7:0]          col_q [COL_DLY];
    logic [7:0]          col_d [COL_DLY];

    logic hRaw;
    logic vRaw;
    logic visRaw;
    logic visTap;

    // Raw sync and visibility decode for the pixel currently on x/y.
    always_comb begin
        hRaw   = !((x_q >= H_SYNC_START) && (x_q < H_SYNC_END));
        vRaw   = !((y_q >= V_SYNC_START) && (y_q < V_SYNC_END));
        visRaw = (x_q < H_VIS_END) && (y_q < V_VIS_END);
        visTap = (PIPE_DLY > 1) ? visD1_q : visRaw;
    end

    // Divider, strobe and raster counters; en is registered so it lines up with div==CLK_DIV-1.
    always_comb begin
        div_d = (div_q == DIV_LAST) ? 4'd0 : div_q + 4'd1;
        x_d   = x_q;
        y_d   = y_q;
        if (en_q) begin
            if (x_q == H_LAST) begin
                x_d = 10'd0;
                y_d = (y_q == V_LAST) ? 10'd0 : y_q + 10'd1;
            end else begin
                x_d = x_q + 10'd1;
            end
        end
        en_d = (div_d == DIV_LAST);
        fs_d = en_d && (x_d == 10'd0) && (y_d == 10'd0);
    end

    // Sync/visibility shift registers and the blanked colour register, stepped once per pixel.
    always_comb begin
        hPipe_d = hPipe_q;
        vPipe_d = vPipe_q;
        visD1_d = visD1_q;
        col_d   = col_q;
        if (en_q) begin
            hPipe_d[0] = hRaw;
            vPipe_d[0] = vRaw;
            for (int i = 1; i < PIPE_DLY; i++) begin
                hPipe_d[i] = hPipe_q[i-1];
                vPipe_d[i] = vPipe_q[i-1];
            end
            visD1_d  = visRaw;
            col_d[0] = visTap ? rgb : 8'h00;
            for (int i = 1; i < COL_DLY; i++) begin
                col_d[i] = col_q[i-1];
            end
        end
    end

    // State register; reset parks every pipe stage in its inactive state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q   <= 4'd0;
            en_q    <= 1'b0;
            fs_q    <= 1'b0;
            x_q     <= 10'd0;
            y_q     <= 10'd0;
            hPipe_q <= '1;
            vPipe_q <= '1;
            visD1_q <= 1'b0;
            for (int i = 0; i < COL_DLY; i++) begin
                col_q[i] <= 8'h00;
            end
        end else begin
            div_q   <= div_d;
            en_q    <= en_d;
            fs_q    <= fs_d;
            x_q     <= x_d;
            y_q     <= y_d;
            hPipe_q <= hPipe_d;
            vPipe_q <= vPipe_d;
            visD1_q <= visD1_d;
            col_q   <= col_d;
        end
    end

    assign x           = x_q;
    assign y           = y_q;
    assign en          = en_q;
    assign frame_start = fs_q;
    assign hsync       = hPipe_q[PIPE_DLY-1];
    assign vsync       = vPipe_q[PIPE_DLY-1];
    assign red         = col_q[COL_DLY-1][7:5];
    assign green       = col_q[COL_DLY-1][4:2];
    assign blue        = col_q[COL_DLY-1][1:0];

endmodule

// File: tb/tb_vga_timing.sv
// tb_vga_timing: scoreboard bench for vga_timing. The horizontal timing keeps
// its 640x480 values; the vertical timing is shrunk to 8 lines per frame so
// two whole frames fit in a short run.

module tb_vga_timing;

    localparam int HT = 800;
    localparam int VT = 8;
    localparam int CD = 4;
    localparam int PD = 2;

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       fs;
        logic       hs;
        logic       vs;
        logic [7:0] col;
        logic       dir;
        logic [7:0] dirCol;
    } expEntry_t;

    logic       clk;
    logic       rst_n;
    logic [7:0] rgb;
    logic [9:0] x;
    logic [9:0] y;
    logic       en;
    logic       frame_start;
    logic       hsync;
    logic       vsync;
    logic [2:0] red;
    logic [2:0] green;
    logic [1:0] blue;

    logic [9:0] addrQ;
    bit         modeX;
    bit         done;
    int         vectorsApplied;
    int         miscompares;
    int         fsCount;
    expEntry_t  sbQ [$];

    vga_timing #(
        .V_VISIBLE(4),
        .V_FP     (1),
        .V_SYNC   (2),
        .V_BP     (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rgb        (rgb),
        .x          (x),
        .y          (y),
        .en         (en),
        .frame_start(frame_start),
        .hsync      (hsync),
        .vsync      (vsync),
        .red        (red),
        .green      (green),
        .blue       (blue)
    );

    // 100 MHz system clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Sprite model: registered address, ROM returns the low byte of the address.
    always @(posedge clk) begin
        if (!rst_n) addrQ <= 10'd0;
        else if (en) addrQ <= x;
    end

    assign rgb = modeX ? addrQ[7:0] : 8'hFF;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectorsApplied++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at t=%0t", name, actual, expected, $time);
        end
    endtask

    // Expected outputs during the k-th pixel period after reset release.
    function automatic expEntry_t expectAt(input int k, input bit mx);
        expEntry_t e;
        int n;
        int nx;
        int ny;
        e      = '0;
        e.x    = 10'(k % HT);
        e.y    = 10'((k / HT) % VT);
        e.fs   = ((k % (HT * VT)) == 0);
        e.hs   = 1'b1;
        e.vs   = 1'b1;
        e.col  = 8'h00;
        if (k >= PD) begin
            n  = k - PD;
            nx = n % HT;
            ny = (n / HT) % VT;
            e.hs = !(nx >= 656 && nx < 752);
            e.vs = !(ny >= 5 && ny < 7);
            if (nx < 640 && ny < 4) e.col = mx ? 8'(nx) : 8'hFF;
        end
        return e;
    endfunction

    // Queue the expected stream for one phase, tagging hand-computed colour checkpoints.
    task automatic applyStimulus(input int nPixels, input bit mx);
        int        dirK   [4];
        logic [7:0] dirVal [4];
        expEntry_t e;
        if (mx) begin
            dirK = '{PD + 0, PD + 255, PD + 639, PD + 640};
            dirVal = '{8'h00, 8'hFF, 8'h7F, 8'h00};
        end else begin
            dirK = '{PD + 639, PD + 640, PD + 3*800 + 639, PD + 4*800};
            dirVal = '{8'hFF, 8'h00, 8'hFF, 8'h00};
        end
        modeX = mx;
        for (int k = 0; k < nPixels; k++) begin
            e = expectAt(k, mx);
            for (int j = 0; j < 4; j++) begin
                if (k == dirK[j]) begin
                    e.dir    = 1'b1;
                    e.dirCol = dirVal[j];
                end
            end
            sbQ.push_back(e);
        end
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_x"}, 32'(x), 32'd0);
        checkOutput({tag, "_y"}, 32'(y), 32'd0);
        checkOutput({tag, "_en"}, 32'(en), 32'd0);
        checkOutput({tag, "_frameStart"}, 32'(frame_start), 32'd0);
        checkOutput({tag, "_hsync"}, 32'(hsync), 32'd1);
        checkOutput({tag, "_vsync"}, 32'(vsync), 32'd1);
        checkOutput({tag, "_colour"}, 32'({red, green, blue}), 32'd0);
    endtask

    // Monitor: pops one expectation per en pulse, checks strobe period and output hold.
    initial begin
        int          gap;
        bit          seenEn;
        bit          prevValid;
        bit          prevEn;
        logic [29:0] snap;
        logic [29:0] prevSnap;
        int          hsLow;
        int          vsLow;
        expEntry_t   e;
        gap = 0; seenEn = 0; prevValid = 0; prevEn = 0; prevSnap = '0;
        hsLow = 0; vsLow = 0;
        forever begin
            @(negedge clk);
            if (!done) begin
                if (!rst_n) begin
                    gap = 0; seenEn = 0; prevValid = 0;
                    hsLow = 0; vsLow = 0; fsCount = 0;
                end else begin
                    gap++;
                    snap = {x, y, hsync, vsync, red, green, blue};
                    if (prevValid && !prevEn) checkOutput("holdBetweenEn", 32'(snap), 32'(prevSnap));
                    if (en) begin
                        checkOutput("enPeriod", 32'(gap), seenEn ? 32'(CD) : 32'(CD - 1));
                        if (frame_start) begin
                            if (seenEn) checkOutput("vsyncLowPerFrame", 32'(vsLow), 32'd1600);
                            vsLow = 0;
                            fsCount++;
                        end
                        if (x == 10'd0) begin
                            if (seenEn) checkOutput("hsyncLowPerLine", 32'(hsLow), 32'd96);
                            hsLow = 0;
                        end
                        if (!hsync) hsLow++;
                        if (!vsync) vsLow++;
                        gap = 0;
                        seenEn = 1;
                        if (sbQ.size() == 0) begin
                            vectorsApplied++;
                            miscompares++;
                            $display("[TB] FAIL unexpectedEn: got en at x=%0d y=%0d, expected none at t=%0t", x, y, $time);
                        end else begin
                            e = sbQ.pop_front();
                            checkOutput("x", 32'(x), 32'(e.x));
                            checkOutput("y", 32'(y), 32'(e.y));
                            checkOutput("frameStart", 32'(frame_start), 32'(e.fs));
                            checkOutput("hsync", 32'(hsync), 32'(e.hs));
                            checkOutput("vsync", 32'(vsync), 32'(e.vs));
                            checkOutput("colour", 32'({red, green, blue}), 32'(e.col));
                            if (e.dir) checkOutput("colourCheckpoint", 32'({red, green, blue}), 32'(e.dirCol));
                        end
                    end else begin
                        checkOutput("frameStartOnlyWithEn", 32'(frame_start), 32'd0);
                    end
                    prevSnap  = snap;
                    prevEn    = en;
                    prevValid = 1;
                end
            end
        end
    end

    // Stimulus: reset, two frames of white, mid-frame reset, one line of the address-pattern sprite.
    initial begin
        bit ok;
        rst_n = 1'b0;
        modeX = 1'b0;
        done  = 1'b0;
        vectorsApplied = 0;
        miscompares    = 0;
        fsCount        = 0;

        applyStimulus(2*HT*VT + 2*HT + 300, 1'b0);
        repeat (5) @(posedge clk);
        @(negedge clk);
        checkResetValues("reset");
        #1 rst_n = 1'b1;

        ok = 0;
        for (int c = 0; c < (2*HT*VT + 2*HT + 310) * CD; c++) begin
            @(negedge clk);
            if (sbQ.size() == 0 && x == 10'd300 && y == 10'd2) begin
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            vectorsApplied++;
            miscompares++;
            $display("[TB] FAIL phaseA_timeout: got %0d entries left, expected 0 with x=300 y=2", sbQ.size());
        end else begin
            checkOutput("frameStartCount", 32'(fsCount), 32'd3);
            @(negedge clk);
            @(negedge clk);
            #1 rst_n = 1'b0;
            sbQ.delete();
            applyStimulus(HT + PD, 1'b1);
            @(negedge clk);
            checkResetValues("midReset");
            #1 rst_n = 1'b1;

            ok = 0;
            for (int c = 0; c < (HT + PD + 10) * CD; c++) begin
                @(negedge clk);
                if (sbQ.size() == 0) begin
                    ok = 1;
                    break;
                end
            end
            if (!ok) begin
                vectorsApplied++;
                miscompares++;
                $display("[TB] FAIL phaseB_timeout: got %0d entries left, expected 0", sbQ.size());
            end
        end

        done = 1'b1;
        $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
        $finish;
    end

endmodule
